pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline stage that replaces the plain enable-only stage registers between CPU pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It adds:
- a valid/ready handshake,
- a DEPTH-entry skid buffer that absorbs downstream stalls,
- a synchronous flush for branch/jump squash,
- a saturating upstream-stall counter for performance debug.

One instance per stage boundary; DATA_W covers the concatenated stage payload.

---
 rtl/pipe_stage_buf.sv | 134 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Elastic pipeline stage placed between CPU pipeline stages. It holds up to
// DEPTH payloads in a circular buffer, exchanges them with valid/ready
// handshakes on both sides, squashes all buffered entries on a synchronous
// flush and counts upstream stall cycles for performance debug.
//
// Parameters
//   DATA_W  payload width in bits (1..256)
//   DEPTH   buffer entries, power of two, 2..16
//   CNT_W   stall counter width
//
// Ports
//   clk        main clock, all state updates on the rising edge
//   arst       asynchronous active-high reset
//   enable     global run enable; 0 freezes all state (flush still applies)
//   flush      synchronous squash of all buffered entries
//   in_valid   upstream has a payload
//   in_ready   stage can accept a payload (registered state and enable only)
//   in_data    upstream payload
//   out_valid  head entry is valid
//   out_ready  downstream accepts the head entry
//   out_data   head entry payload, zero when the buffer is empty
//   count      current occupancy (registered)
//   stall_cnt  saturating count of cycles with in_valid=1 and in_ready=0
//   stall_clr  synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt,
  input  logic                       stall_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic push;
  logic pop;
  logic stall;

  // Handshake signals are derived from registered occupancy only, so there is
  // no combinational path from out_ready to in_ready. A full buffer therefore
  // refuses a push even while it is popping; in_ready rises one cycle later.
  assign in_ready  = enable & (count != OCC_FULL);
  assign out_valid = enable & (count != '0);
  assign out_data  = (count != '0) ? mem[rd_ptr] : '0;

  // Both strobes already include enable, so enable=0 blocks every update
  // below except flush.
  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign stall = enable & in_valid & ~in_ready;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // modulo DEPTH by plain binary overflow.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush wins over any push/pop in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage. Flush leaves the contents in place; the zeroed pointers
  // and count make them unreachable.
  // NOTE: the storage array is reset here because reset must also present
  // zeros on every entry; without that requirement it would be left
  // unreset so it can map onto plain (non-resettable) flops or RAM.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Upstream stall counter: saturating, clear has priority over increment,
  // frozen while enable=0, untouched by flush.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= '0;
    end else if (enable) begin
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (stall && (stall_cnt != STALL_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Two instances run side by side on one clock:
//   u_d2 : DEPTH=2, CNT_W=16  (streaming, backpressure, stall clear)
//   u_d4 : DEPTH=4, CNT_W=4   (full+pop, wrap, flush, freeze, saturation)
// Every cycle a queue-based reference model checks handshakes, head data,
// occupancy and stall count of both instances; a vector table with
// hand-derived expectations drives u_d2, and short sequences cover the
// multi-cycle corner cases on u_d4 plus an asynchronous reset pulse.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;

  // Per-instance inputs, index 0 = u_d2, index 1 = u_d4.
  logic [1:0]         en, fl, clr, iv, orr;
  logic [1:0][DW-1:0] din;

  logic          ir0, ov0, ir1, ov1;
  logic [DW-1:0] dout0, dout1;
  logic [1:0]    cnt0;
  logic [2:0]    cnt1;
  logic [15:0]   st0;
  logic [3:0]    st1;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .arst(arst), .enable(en[0]), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir0), .in_data(din[0]),
    .out_valid(ov0), .out_ready(orr[0]), .out_data(dout0),
    .count(cnt0), .stall_cnt(st0), .stall_clr(clr[0])
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(4), .CNT_W(4)) u_d4 (
    .clk(clk), .arst(arst), .enable(en[1]), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir1), .in_data(din[1]),
    .out_valid(ov1), .out_ready(orr[1]), .out_data(dout1),
    .count(cnt1), .stall_cnt(st1), .stall_clr(clr[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: scoreboard queues of accepted payloads and stall counts.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            ms[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] g_ir(int i);  return (i == 0) ? 32'(ir0)   : 32'(ir1);   endfunction
  function automatic logic [31:0] g_ov(int i);  return (i == 0) ? 32'(ov0)   : 32'(ov1);   endfunction
  function automatic logic [31:0] g_d(int i);   return (i == 0) ? 32'(dout0) : 32'(dout1); endfunction
  function automatic logic [31:0] g_cnt(int i); return (i == 0) ? 32'(cnt0)  : 32'(cnt1);  endfunction
  function automatic logic [31:0] g_st(int i);  return (i == 0) ? 32'(st0)   : 32'(st1);   endfunction

  // ctl = {enable, flush, stall_clr, in_valid, out_ready}
  task automatic drive(input int i, input logic [4:0] ctl, input logic [DW-1:0] d);
    {en[i], fl[i], clr[i], iv[i], orr[i]} = ctl;
    din[i] = d;
  endtask

  task automatic idle_all();
    drive(0, 5'b10000, 8'h00);
    drive(1, 5'b10000, 8'h00);
  endtask

  // Called at a falling edge with inputs already driven. Checks both
  // instances against the model, advances one rising edge, updates the
  // model and returns at the next falling edge.
  task automatic tick();
    logic [1:0] p_push, p_pop, p_stall;
    #1;
    for (int i = 0; i < 2; i++) begin
      int            occ;
      int            dep;
      logic          e_ir, e_ov;
      logic [DW-1:0] e_d;
      occ  = (i == 0) ? q0.size() : q1.size();
      dep  = (i == 0) ? 2 : 4;
      e_ir = en[i] && (occ != dep);
      e_ov = en[i] && (occ != 0);
      e_d  = '0;
      if (occ != 0) e_d = (i == 0) ? q0[0] : q1[0];
      check($sformatf("d%0d in_ready", i),  g_ir(i),  32'(e_ir));
      check($sformatf("d%0d out_valid", i), g_ov(i),  32'(e_ov));
      check($sformatf("d%0d out_data", i),  g_d(i),   32'(e_d));
      check($sformatf("d%0d count", i),     g_cnt(i), 32'(occ));
      check($sformatf("d%0d stall_cnt", i), g_st(i),  32'(ms[i]));
      p_push[i]  = iv[i] & e_ir;
      p_pop[i]   = e_ov & orr[i];
      p_stall[i] = en[i] & iv[i] & ~e_ir;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int smax;
      smax = (i == 0) ? 65535 : 15;
      if (fl[i]) begin
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (p_pop[i]) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (p_push[i]) begin
          if (i == 0) q0.push_back(din[i]); else q1.push_back(din[i]);
        end
      end
      if (en[i]) begin
        if (clr[i]) ms[i] = 0;
        else if (p_stall[i] && ms[i] < smax) ms[i] = ms[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  // Vector table for u_d2; expectations are the values seen before the edge.
  typedef struct {
    logic [4:0]    ctl;
    logic [DW-1:0] d;
    logic          e_ir;
    logic          e_ov;
    logic [DW-1:0] e_d;
    int            e_cnt;
    int            e_st;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  function automatic vec_t mk(logic [4:0] c, logic [DW-1:0] d, logic [1:0] eo,
                              logic [DW-1:0] ed, int ec, int es);
    vec_t v;
    v.ctl = c; v.d = d; v.e_ir = eo[1]; v.e_ov = eo[0];
    v.e_d = ed; v.e_cnt = ec; v.e_st = es;
    return v;
  endfunction

  initial begin
    //               ctl        data    ir,ov  head   cnt stall
    tbl[0]  = mk(5'b10011, 8'h11, 2'b10, 8'h00, 0, 0); // stream
    tbl[1]  = mk(5'b10011, 8'h22, 2'b11, 8'h11, 1, 0);
    tbl[2]  = mk(5'b10011, 8'h33, 2'b11, 8'h22, 1, 0);
    tbl[3]  = mk(5'b10001, 8'h00, 2'b11, 8'h33, 1, 0);
    tbl[4]  = mk(5'b10001, 8'h00, 2'b10, 8'h00, 0, 0);
    tbl[5]  = mk(5'b10010, 8'hA0, 2'b10, 8'h00, 0, 0); // backpressure fill
    tbl[6]  = mk(5'b10010, 8'hA1, 2'b11, 8'hA0, 1, 0);
    tbl[7]  = mk(5'b10010, 8'hA2, 2'b01, 8'hA0, 2, 0);
    tbl[8]  = mk(5'b10010, 8'hA3, 2'b01, 8'hA0, 2, 1);
    tbl[9]  = mk(5'b10011, 8'hA2, 2'b01, 8'hA0, 2, 2); // full: pop only
    tbl[10] = mk(5'b10011, 8'hA2, 2'b11, 8'hA1, 1, 3); // A2 accepted
    tbl[11] = mk(5'b10001, 8'h00, 2'b11, 8'hA2, 1, 3);
    tbl[12] = mk(5'b10001, 8'h00, 2'b10, 8'h00, 0, 3);
    tbl[13] = mk(5'b10100, 8'h00, 2'b10, 8'h00, 0, 3); // stall_clr
    tbl[14] = mk(5'b10000, 8'h00, 2'b10, 8'h00, 0, 0);

    ms[0] = 0;
    ms[1] = 0;
    arst  = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);

    // Reset state.
    check("reset d2 in_ready",  32'(ir0),   32'd1);
    check("reset d2 out_valid", 32'(ov0),   32'd0);
    check("reset d2 out_data",  32'(dout0), 32'd0);
    check("reset d4 count",     32'(cnt1),  32'd0);
    check("reset d4 stall_cnt", 32'(st1),   32'd0);
    arst = 1'b0;

    // Table-driven stream / backpressure / clear on u_d2.
    for (int k = 0; k < NV; k++) begin
      drive(0, tbl[k].ctl, tbl[k].d);
      drive(1, 5'b10000, 8'h00);
      #1;
      check($sformatf("vec%0d in_ready", k),  32'(ir0),   32'(tbl[k].e_ir));
      check($sformatf("vec%0d out_valid", k), 32'(ov0),   32'(tbl[k].e_ov));
      check($sformatf("vec%0d out_data", k),  32'(dout0), 32'(tbl[k].e_d));
      check($sformatf("vec%0d count", k),     32'(cnt0),  32'(tbl[k].e_cnt));
      check($sformatf("vec%0d stall_cnt", k), 32'(st0),   32'(tbl[k].e_st));
      tick();
    end

    // Full plus simultaneous pop on u_d4, then sustained push+pop with wrap.
    idle_all();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'b10010, 8'(8'h40 + k));
      tick();
    end
    check("d4 full count", 32'(cnt1), 32'd4);
    drive(1, 5'b10011, 8'h44);
    tick();
    check("d4 full+pop count", 32'(cnt1), 32'd3);
    for (int k = 0; k < 8; k++) begin
      drive(1, 5'b10011, 8'(8'h44 + k));
      tick();
    end
    check("d4 steady count", 32'(cnt1), 32'd3);
    drive(1, 5'b10001, 8'h00);
    repeat (3) tick();

    // Flush with a coinciding push on u_d4.
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'b10010, 8'(8'h61 + k));
      tick();
    end
    drive(1, 5'b11010, 8'h55);
    tick();
    check("flush count",     32'(cnt1),  32'd0);
    check("flush out_valid", 32'(ov1),   32'd0);
    check("flush out_data",  32'(dout1), 32'd0);
    drive(1, 5'b10001, 8'h00);
    repeat (2) tick();

    // Enable freeze on u_d4 with two entries buffered.
    for (int k = 0; k < 2; k++) begin
      drive(1, 5'b10010, 8'(8'h71 + k));
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      logic b;
      b = k[0];
      drive(1, {3'b000, b, ~b}, 8'(8'hE0 + k));
      tick();
    end
    check("freeze count",    32'(cnt1),  32'd2);
    check("freeze out_data", 32'(dout1), 32'h71);

    // Stall counter saturation and clear (CNT_W=4).
    for (int k = 0; k < 2; k++) begin
      drive(1, 5'b10010, 8'(8'h73 + k));
      tick();
    end
    drive(1, 5'b10010, 8'hEE);
    repeat (20) tick();
    check("stall saturated", 32'(st1), 32'd15);
    drive(1, 5'b10100, 8'h00);
    tick();
    check("stall cleared", 32'(st1), 32'd0);

    // Asynchronous reset mid-cycle with two entries in each instance.
    for (int k = 0; k < 2; k++) begin
      drive(0, 5'b10010, 8'(8'hB0 + k));
      drive(1, 5'b10001, 8'h00);
      tick();
    end
    idle_all();
    #2;
    arst = 1'b1;
    #1;
    check("arst d2 out_valid", 32'(ov0),   32'd0);
    check("arst d2 count",     32'(cnt0),  32'd0);
    check("arst d2 out_data",  32'(dout0), 32'd0);
    check("arst d4 out_valid", 32'(ov1),   32'd0);
    check("arst d4 count",     32'(cnt1),  32'd0);
    check("arst d4 out_data",  32'(dout1), 32'd0);
    #1;
    arst = 1'b0;
    q0.delete();
    q1.delete();
    ms[0] = 0;
    ms[1] = 0;
    @(negedge clk);
    drive(1, 5'b10011, 8'h5A);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
